// File: rtl/axis_out_framer_pkg.sv
// Shared types and sizing helpers for the framed AXI4-Stream output stage.
package axiso_framer_pkg;

  localparam int AXISO_DATA_W = 24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } framer_state_e;

  typedef struct packed {
    logic [AXISO_DATA_W-1:0] data;
    logic                    tlast;
    logic                    tuser;
  } axiso_entry_t;

  // A geometry of 1 still needs a 1-bit counter
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int AXISO_COL_W = cnt_w(3840);
  localparam int AXISO_ROW_W = cnt_w(2160);

endpackage

// File: rtl/axis_skid_buf.sv
// 2-entry buffer with registered input ready; output is driven from the head entry.
module axis_skid_buf #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_next,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occ_next
);

  logic [1:0][W-1:0] mem;
  logic              rptr, wptr;
  logic [1:0]        occ;
  logic              push, pop;

  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_valid = (occ != 2'd0);
  assign out_data  = mem[rptr];
  assign occ_next  = occ + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem      <= '0;
      rptr     <= 1'b0;
      wptr     <= 1'b0;
      occ      <= 2'd0;
      in_ready <= 1'b0;
    end else begin
      if (push) begin
        mem[wptr] <= in_data;
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      occ      <= occ_next;
      // Ready looks one cycle ahead so it can be a flop
      in_ready <= en_next && (occ_next != 2'd2);
    end
  end

endmodule

// File: rtl/axis_out_framer.sv
// Frames the unframed pixel stream: tuser on first pixel of a frame, tlast on row end.
// Optional beat counter port enabled by defining AXISO_BEAT_CNT_EN.
module axis_out_framer
  import axiso_framer_pkg::*;
#(
  parameter int AXISOUT_DATA_WIDTH = AXISO_DATA_W,
  parameter int DST_IMG_WIDTH      = 3840,
  parameter int DST_IMG_HEIGHT     = 2160
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            frame_start,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [AXISOUT_DATA_WIDTH-1:0]   s_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [AXISOUT_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [AXISOUT_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tuser,
  output logic                            frame_busy,
  output logic                            frame_done
`ifdef AXISO_BEAT_CNT_EN
  ,output logic [31:0]                    beat_cnt
`endif
);

  localparam int COL_W = cnt_w(DST_IMG_WIDTH);
  localparam int ROW_W = cnt_w(DST_IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(DST_IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DST_IMG_HEIGHT - 1);

  framer_state_e    state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  axiso_entry_t     in_ent, out_ent;
  logic             s_hs, m_hs, row_end, frame_end, en_next;
  logic [1:0]       occ_next;

  assign s_hs      = s_axis_tvalid && s_axis_tready;
  assign m_hs      = m_axis_tvalid && m_axis_tready;
  assign row_end   = (col == COL_LAST);
  assign frame_end = row_end && (row == ROW_LAST);
  // Will the FSM be in ACTIVE next cycle; feeds the registered ready
  assign en_next   = (state == IDLE && frame_start) ||
                     (state == ACTIVE && !(s_hs && frame_end));

  assign in_ent.data  = s_axis_tdata;
  assign in_ent.tlast = row_end;
  assign in_ent.tuser = (col == '0) && (row == '0);

  axis_skid_buf #(.W($bits(axiso_entry_t))) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_next   (en_next),
    .in_valid  (s_axis_tvalid),
    .in_ready  (s_axis_tready),
    .in_data   (in_ent),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready),
    .out_data  (out_ent),
    .occ_next  (occ_next)
  );

  assign m_axis_tdata = out_ent.data;
  assign m_axis_tlast = out_ent.tlast;
  assign m_axis_tuser = out_ent.tuser;
  assign m_axis_tkeep = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: if (frame_start) begin
          state      <= ACTIVE;
          col        <= '0;
          row        <= '0;
          frame_busy <= 1'b1;
        end
        ACTIVE: if (s_hs) begin
          if (row_end) begin
            col <= '0;
            if (frame_end) begin
              row   <= '0;
              state <= DRAIN;
            end else begin
              row <= row + 1'b1;
            end
          end else begin
            col <= col + 1'b1;
          end
        end
        DRAIN: if (occ_next == 2'd0) begin
          // Buffer empties this edge: done lines up with the cycle after the last pop
          frame_done <= 1'b1;
          frame_busy <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXISO_BEAT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             beat_cnt <= '0;
    else if (state == IDLE && frame_start)  beat_cnt <= '0;
    else if (m_hs && beat_cnt != '1)        beat_cnt <= beat_cnt + 1'b1;
  end
`endif

endmodule
